axis_shift_link: RTL and testbench
==================================

AXIS_SHIFT_LINK -- requirements
Module: axis_shift_link

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXIS word width and serial payload bits per frame (legal range 1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of RX FIFO depth.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the drop counter.
REQ-004 SHALL have port aclk, input, 1: the single clock for all logic.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port sel, input, 1: link selected; low aborts the current frame.
REQ-007 SHALL have port shift, input, 1: single-cycle strobe, advances one serial bit.
REQ-008 SHALL have port tdi, input, 1: serial receive bit, sampled when sel&shift.
REQ-009 SHALL have port tdo, output, 1: serial transmit bit for the current bit position.
REQ-010 SHALL have ports s_axis_tdata/tvalid/tready, in/in/out, DATA_WIDTH/1/1: TX word stream.
REQ-011 SHALL have ports m_axis_tdata/tvalid/tready, out/out/in, DATA_WIDTH/1/1: RX word stream.
REQ-012 SHALL have port drop_count, output, CNT_WIDTH: RX words dropped on FIFO full.

Function
REQ-013 SHALL use a frame of DATA_WIDTH+1 bits: bit 0 is the flag (1 = word present), bits 1..DATA_WIDTH are payload, LSB first.
REQ-014 SHALL keep bit_cnt in 0..DATA_WIDTH, incremented on each sel&shift cycle; it wraps DATA_WIDTH->0, and sel low forces 0 on the next edge.
REQ-015 SHALL hold the TX word in one register with hold_valid; s_axis_tready = ~hold_valid, and a transfer sets hold_valid and loads hold_data.
REQ-016 SHALL drive tdo combinationally: hold_valid at bit_cnt 0, tx_sr[0] otherwise; tx_sr is the registered shift copy of hold_data.
REQ-017 SHALL, on sel&shift at bit_cnt 0, load tx_sr with hold_data (zeros if ~hold_valid) and latch tx_flag = hold_valid; on other bits, shift tx_sr right by one.
REQ-018 SHALL clear hold_valid only on sel&shift at bit_cnt DATA_WIDTH with tx_flag=1, so a frame aborted by sel low retransmits the same word.
REQ-019 SHALL NOT load a new s_axis word in the same cycle hold_valid is cleared; tready rises the cycle after.
REQ-020 SHALL capture tdi into rx_flag at bit 0 and shift tdi into rx_sr from the MSB end for bits 1..DATA_WIDTH.
REQ-021 SHALL, on sel&shift at bit_cnt DATA_WIDTH with rx_flag=1, write {tdi, rx_sr[DATA_WIDTH-1:1]} to the RX FIFO; flag 0 frames are discarded.
REQ-022 SHALL make the RX FIFO first-word-fall-through; m_axis_tvalid rises the cycle after the write, giving 1-cycle latency from the final strobe.
REQ-023 SHALL accept a write when full only if m_axis_tvalid&tready in the same cycle; otherwise the word is dropped and drop_count increments, saturating at all-ones.
REQ-024 SHALL discard a partial RX frame when sel falls; no FIFO write occurs.
REQ-025 SHALL ignore shift while sel=0, and tdo SHALL then equal hold_valid.

Reset
REQ-026 SHALL, on aresetn low, asynchronously clear bit_cnt, hold_valid, hold_data, tx_sr, tx_flag, rx_sr, rx_flag, FIFO pointers/count and drop_count.
REQ-027 SHALL present outputs during reset as s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, tdo=0 and drop_count=0; s_axis_tready rises the first cycle after release.

Structure
REQ-028 SHALL hold nothing in a shared package; frame-length localparam (DATA_WIDTH+1) and the bit_cnt width ($clog2 of frame length) are local to the module.
REQ-029 SHALL implement the RX FIFO as sub-module shift_link_fifo (sync FWFT, parameters DATA_WIDTH/ADDR_WIDTH, full/empty from an ADDR_WIDTH+1 count).

Verification (DATA_WIDTH=8, ADDR_WIDTH=2)
REQ-030 SHALL cover: s_axis word 0xA5 followed by 9 strobes -> tdo = 1,1,0,1,0,0,1,0,1 and tready re-rises 2 cycles after the 9th strobe.
REQ-031 SHALL cover: tdi frame 1 then 0x3C LSB first -> m_axis_tdata=0x3C with tvalid 1 cycle after the 9th strobe; a flag-0 frame -> no output.
REQ-032 SHALL cover: a word 0x81 where sel drops after 4 strobes, followed by a full frame -> tdo frame carries 0x81 again and tready stays 0 until its completion.
REQ-033 SHALL cover: 5 flagged RX frames with m_axis_tready=0 -> 4 words held and drop_count=1; the same with tready=1 on the 5th write -> no drop.
REQ-034 SHALL cover: aresetn asserted mid-frame at bit 5 -> all outputs are zero immediately, and after release the next frame starts at bit 0.
REQ-035 SHALL cover: idle TX over 9 strobes -> tdo constant 0 for the whole frame.

Source files
------------

// File: rtl/axis_shift_link_if.sv
// rtl/axis_shift_link_if.sv - AXI-Stream word channel bundle (tdata/tvalid/tready)
interface axis_shift_link_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/axis_shift_link_fifo.sv
// rtl/axis_shift_link_fifo.sv - shift_link_fifo: synchronous first-word-fall-through RX FIFO
module shift_link_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  assign full    = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q + (ADDR_WIDTH + 1)'(do_wr) - (ADDR_WIDTH + 1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/axis_shift_link.sv
// rtl/axis_shift_link.sv - serial shift link: one flagged word frame per DATA_WIDTH+1 strobes,
// TX word from s_axis, RX words to m_axis through a FWFT FIFO with drop counting.
module axis_shift_link #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  sel,
  input  logic                  shift,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  localparam int             FRAME_LEN = DATA_WIDTH + 1;
  localparam int             CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_WIDTH);

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic                  tx_flag_q, tx_flag_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic                  rx_flag_q, rx_flag_d;
  logic                  tready_q, tready_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  strobe, at_first, at_last, tx_done, s_fire, rx_wr, m_fire, drop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   rx_cat;
  logic [DATA_WIDTH-1:0] rx_word;

  assign strobe   = sel & shift;
  assign at_first = (bit_cnt_q == '0);
  assign at_last  = (bit_cnt_q == LAST_BIT);
  assign tx_done  = strobe & at_last & tx_flag_q;
  assign s_fire   = s_axis_tvalid & tready_q;
  assign rx_cat   = {tdi, rx_sr_q};
  assign rx_word  = rx_cat[DATA_WIDTH:1];
  assign rx_wr    = strobe & at_last & rx_flag_q;
  assign m_fire   = m_axis_tvalid & m_axis_tready;
  assign drop     = rx_wr & fifo_full & ~m_fire;

  assign tdo           = at_first ? hold_valid_q : tx_sr_q[0];
  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = ~fifo_empty;
  assign drop_count    = drop_count_q;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    tx_sr_d      = tx_sr_q;
    tx_flag_d    = tx_flag_q;
    rx_sr_d      = rx_sr_q;
    rx_flag_d    = rx_flag_q;
    drop_count_d = drop_count_q;

    if (!sel)       bit_cnt_d = '0;
    else if (shift) bit_cnt_d = at_last ? '0 : bit_cnt_q + CW'(1);

    if (strobe) begin
      if (at_first) begin
        tx_sr_d   = hold_valid_q ? hold_data_q : '0;
        tx_flag_d = hold_valid_q;
        rx_flag_d = tdi;
      end else begin
        tx_sr_d = tx_sr_q >> 1;
        rx_sr_d = rx_word;
      end
    end

    // The held word survives aborted frames; only a completed flagged frame releases it.
    if (tx_done) begin
      hold_valid_d = 1'b0;
    end else if (s_fire) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_axis_tdata;
    end
    tready_d = ~hold_valid_d & ~tx_done;

    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      tx_sr_q      <= '0;
      tx_flag_q    <= 1'b0;
      rx_sr_q      <= '0;
      rx_flag_q    <= 1'b0;
      tready_q     <= 1'b0;
      drop_count_q <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      tx_sr_q      <= tx_sr_d;
      tx_flag_q    <= tx_flag_d;
      rx_sr_q      <= rx_sr_d;
      rx_flag_q    <= rx_flag_d;
      tready_q     <= tready_d;
      drop_count_q <= drop_count_d;
    end
  end

  shift_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (rx_wr),
    .wr_data (rx_word),
    .rd_en   (m_axis_tready),
    .rd_data (m_axis_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_axis_shift_link.sv
// tb/tb_axis_shift_link.sv - self-checking bench for axis_shift_link (DATA_WIDTH=8, ADDR_WIDTH=2)
module tb_axis_shift_link;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CN = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic aresetn, sel, shift, tdi, tdo;
  logic [CN-1:0] drop_count;

  axis_shift_link_if #(.DATA_WIDTH(DW)) s_if ();
  axis_shift_link_if #(.DATA_WIDTH(DW)) m_if ();

  axis_shift_link #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CN)) dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .sel           (sel),
    .shift         (shift),
    .tdi           (tdi),
    .tdo           (tdo),
    .s_axis_tdata  (s_if.tdata),
    .s_axis_tvalid (s_if.tvalid),
    .s_axis_tready (s_if.tready),
    .m_axis_tdata  (m_if.tdata),
    .m_axis_tvalid (m_if.tvalid),
    .m_axis_tready (m_if.tready),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] rx_q [$];
  int drop_model = 0;
  logic [DW:0] t;

  // Frame as it appears on the wire: index 0 is the flag, then payload LSB first.
  function automatic logic [DW:0] frame_of(input logic flag, input logic [DW-1:0] w);
    return flag ? {w, 1'b1} : '0;
  endfunction

  task automatic run_bits(input int n, input logic [DW:0] rx, input logic pop_last,
                          output logic [DW:0] tb);
    tb = '0;
    for (int i = 0; i < n; i++) begin
      sel = 1'b1; shift = 1'b1; tdi = rx[i];
      m_if.tready = pop_last && (i == n - 1);
      #1 tb[i] = tdo;
      @(negedge clk);
    end
    shift = 1'b0; m_if.tready = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int waited = 0;
    while (!s_if.tready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!s_if.tready) begin
      n_err++;
      $display("FAIL send_timeout tready=%b required=1", s_if.tready);
    end
    s_if.tdata = w; s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; sel = 1'b0; shift = 1'b0; tdi = 1'b0;
    s_if.tdata = '0; s_if.tvalid = 1'b0; m_if.tready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, tdo, drop_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got tready=%b tvalid=%b tdata=%h tdo=%b drop=%0d required all 0",
               s_if.tready, m_if.tvalid, m_if.tdata, tdo, drop_count);
    end
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_if.tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_tready got=%b required=1", s_if.tready);
    end
  endtask

  task automatic test_tx_word;
    logic [DW-1:0] pay = DW'($urandom);
    send_word(8'hA5);
    n_cmp++;
    if (s_if.tready !== 1'b0) begin
      n_err++; $display("FAIL tx_tready_low got=%b required=0", s_if.tready);
    end
    run_bits(DW + 1, {pay, 1'b0}, 1'b0, t);
    n_cmp++;
    if (t !== 9'b1_0100_1011) begin
      n_err++; $display("FAIL tx_a5_frame got=%b required=%b", t, 9'b1_0100_1011);
    end
    n_cmp++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL tx_done_plus1 tready=%b tvalid=%b required 0 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (s_if.tready !== 1'b1) begin
      n_err++; $display("FAIL tx_done_plus2 tready=%b required=1", s_if.tready);
    end
  endtask

  task automatic test_rx_word;
    run_bits(DW + 1, frame_of(1'b1, 8'h3C), 1'b0, t);
    n_cmp++;
    if ({m_if.tvalid, m_if.tdata} !== {1'b1, 8'h3C}) begin
      n_err++; $display("FAIL rx_3c got tvalid=%b tdata=%h required 1 3c", m_if.tvalid, m_if.tdata);
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    m_if.tready = 1'b0;
    run_bits(DW + 1, {8'hFF, 1'b0}, 1'b0, t);
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL rx_flag0_discard tvalid=%b required=0", m_if.tvalid);
    end
  endtask

  task automatic test_idle_tx;
    run_bits(DW + 1, {DW'($urandom), 1'b0}, 1'b0, t);
    n_cmp++;
    if (t !== '0) begin
      n_err++; $display("FAIL idle_tdo got=%b required=%b", t, 9'b0);
    end
  endtask

  task automatic test_abort;
    send_word(8'h81);
    run_bits(4, '1, 1'b0, t);
    n_cmp++;
    if (t[3:0] !== 4'b0011) begin
      n_err++; $display("FAIL abort_partial got=%b required=0011", t[3:0]);
    end
    sel = 1'b0; shift = 1'b1;
    repeat (2) @(negedge clk);
    shift = 1'b0;
    n_cmp++;
    if ({tdo, s_if.tready} !== 2'b10) begin
      n_err++; $display("FAIL abort_idle tdo=%b tready=%b required 1 0", tdo, s_if.tready);
    end
    run_bits(DW + 1, '0, 1'b0, t);
    n_cmp++;
    if (t !== frame_of(1'b1, 8'h81)) begin
      n_err++; $display("FAIL abort_retx got=%b required=%b", t, frame_of(1'b1, 8'h81));
    end
    n_cmp++;
    if ({s_if.tready, m_if.tvalid} !== 2'b00) begin
      n_err++; $display("FAIL abort_after tready=%b tvalid=%b required 0 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_fifo_full;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k <= DEPTH; k++) begin
        logic [DW-1:0] w = DW'($urandom);
        logic pop = (pass == 1) && (k == DEPTH);
        run_bits(DW + 1, frame_of(1'b1, w), pop, t);
        if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
        if (rx_q.size() < DEPTH) rx_q.push_back(w);
        else drop_model++;
      end
      n_cmp++;
      if (drop_count !== CN'(drop_model)) begin
        n_err++; $display("FAIL fifo_drop pass=%0d got=%0d required=%0d", pass, drop_count, drop_model);
      end
      m_if.tready = 1'b1;
      while (rx_q.size() > 0) begin
        n_cmp++;
        if ({m_if.tvalid, m_if.tdata} !== {1'b1, rx_q[0]}) begin
          n_err++; $display("FAIL fifo_drain pass=%0d got tvalid=%b tdata=%h required 1 %h",
                            pass, m_if.tvalid, m_if.tdata, rx_q[0]);
        end
        void'(rx_q.pop_front());
        @(negedge clk);
      end
      m_if.tready = 1'b0;
      n_cmp++;
      if (m_if.tvalid !== 1'b0) begin
        n_err++; $display("FAIL fifo_empty pass=%0d tvalid=%b required=0", pass, m_if.tvalid);
      end
    end
  endtask

  task automatic test_reset_midframe;
    run_bits(DW + 1, frame_of(1'b1, 8'h96), 1'b0, t);
    send_word(8'hC3);
    run_bits(5, '0, 1'b0, t);
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, tdo, drop_count} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset got tready=%b tvalid=%b tdata=%h tdo=%b drop=%0d required all 0",
               s_if.tready, m_if.tvalid, m_if.tdata, tdo, drop_count);
    end
    drop_model = 0;
    rx_q.delete();
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    send_word(8'h5A);
    run_bits(DW + 1, '0, 1'b0, t);
    n_cmp++;
    if (t !== frame_of(1'b1, 8'h5A)) begin
      n_err++; $display("FAIL post_reset_frame got=%b required=%b", t, frame_of(1'b1, 8'h5A));
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++) begin
      logic          has_tx = 1'($urandom);
      logic [DW-1:0] tw     = DW'($urandom);
      logic          rf     = 1'($urandom);
      logic [DW-1:0] rw     = DW'($urandom);
      if (has_tx) send_word(tw);
      run_bits(DW + 1, {rw, rf}, 1'b0, t);
      n_cmp++;
      if (t !== frame_of(has_tx, tw)) begin
        n_err++; $display("FAIL rand_tdo it=%0d got=%b required=%b", it, t, frame_of(has_tx, tw));
      end
      n_cmp++;
      if (m_if.tvalid !== rf || (rf && m_if.tdata !== rw)) begin
        n_err++; $display("FAIL rand_rx it=%0d got tvalid=%b tdata=%h required %b %h",
                          it, m_if.tvalid, m_if.tdata, rf, rw);
      end
      m_if.tready = 1'b1;
      @(negedge clk);
      m_if.tready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_tx_word();
    test_rx_word();
    test_idle_tx();
    test_abort();
    test_fifo_full();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
